// File: rtl/osc_slot_scheduler_if.sv
`default_nettype none
// ============================================================================
// osc_slot_scheduler_if : control/status bundle between voice allocator and slot scheduler
// Rev 1.0
// ============================================================================
interface osc_slot_scheduler_if #(
  parameter int VOICES  = 8,
  parameter int V_ENVS  = 8,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3
);
  logic                       run;
  logic                       note_on;
  logic [V_WIDTH-1:0]         note_vx;
  logic [V_WIDTH+E_WIDTH-1:0] xxxx;
  logic                       frame_start;
  logic [V_ENVS-1:0]          osc_accum_zero;
  logic [VOICES-1:0]          reset_pending;
  logic                       running;

  modport master (
    output run, note_on, note_vx,
    input  xxxx, frame_start, osc_accum_zero, reset_pending, running
  );

  modport slave (
    input  run, note_on, note_vx,
    output xxxx, frame_start, osc_accum_zero, reset_pending, running
  );
endinterface
`default_nettype wire

// File: rtl/osc_slot_scheduler.sv
`default_nettype none
// ============================================================================
// osc_slot_scheduler : slot sequencer {vx,ox,oe} with queued per-voice accumulator reset
// Rev 1.0
// ============================================================================
module osc_slot_scheduler #(
  parameter int VOICES   = 8,
  parameter int V_OSC    = 4,
  parameter int V_ENVS   = 8,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int OE_WIDTH = 1,
  parameter int E_WIDTH  = O_WIDTH + OE_WIDTH
) (
  input  wire                      sCLK_XVXOSC,
  input  wire                      reset_data_N,
  osc_slot_scheduler_if.slave      bus
);

  localparam int SW = V_WIDTH + E_WIDTH;
  localparam logic [SW-1:0] c_SLOT_MAX = SW'(VOICES * V_OSC * (2 ** OE_WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [SW-1:0]       r_slot, w_slot_nx;
  logic                r_frame, w_frame_nx;
  logic                r_zero, w_zero_nx;
  logic [VOICES-1:0]   r_pend, w_pend_nx, w_set, w_clr;
  logic [V_WIDTH-1:0]  w_vx_nx;
  logic [E_WIDTH-1:0]  w_e_nx;
  logic                w_active_nx;
  logic                w_serve;

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
    if (!reset_data_N) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_frame <= 1'b0;
      r_zero  <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_slot  <= w_slot_nx;
      r_frame <= w_frame_nx;
      r_zero  <= w_zero_nx;
      r_pend  <= w_pend_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_slot_nx  = r_slot;
    w_set      = '0;
    w_clr      = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_slot_nx = '0;
        if (bus.run) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        w_slot_nx = r_slot + 1'b1;
        if (!bus.run) w_state_nx = ST_STOP;
      end
      ST_STOP: begin
        // Finish the frame; resuming mid-frame keeps the slot sequence continuous.
        w_slot_nx = r_slot + 1'b1;
        if (bus.run)                     w_state_nx = ST_RUN;
        else if (r_slot == c_SLOT_MAX)   w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_slot_nx  = '0;
      end
    endcase

    w_vx_nx     = w_slot_nx[SW-1:E_WIDTH];
    w_e_nx      = w_slot_nx[E_WIDTH-1:0];
    w_active_nx = (w_state_nx != ST_IDLE);
    w_serve     = w_active_nx && (w_e_nx == '0) && r_pend[w_vx_nx];

    if (bus.note_on) w_set[bus.note_vx] = 1'b1;
    if (w_serve)     w_clr[w_vx_nx]     = 1'b1;
    // A new request on the service edge survives: the voice is served once more.
    w_pend_nx = (r_pend & ~w_clr) | w_set;

    if (!w_active_nx)        w_zero_nx = 1'b0;
    else if (w_e_nx == '0)   w_zero_nx = w_serve;
    else                     w_zero_nx = r_zero;

    w_frame_nx = (w_state_nx == ST_RUN) && (w_slot_nx == '0);
  end

  assign bus.xxxx           = r_slot;
  assign bus.frame_start    = r_frame;
  assign bus.osc_accum_zero = {V_ENVS{r_zero}};
  assign bus.reset_pending  = r_pend;
  assign bus.running        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_osc_slot_scheduler.sv
`default_nettype none
// ============================================================================
// tb_osc_slot_scheduler : directed + random checks against a frame-level reference model
// Rev 1.0
// ============================================================================
module tb_osc_slot_scheduler;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  osc_slot_scheduler_if bus ();

  osc_slot_scheduler dut (
    .sCLK_XVXOSC  (clk),
    .reset_data_N (rstn),
    .bus          (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0=idle 1=run 2=stop, slot 0..63, zv = voice being zeroed (-1 none)
  int       m_mode = 0;
  int       m_slot = 0;
  int       m_zv   = -1;
  bit       m_frame = 1'b0;
  bit [7:0] m_pend = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_zv = -1; m_frame = 1'b0; m_pend = '0;
  endtask

  task automatic model_edge(input bit run, input bit non, input int vx);
    bit [7:0] old_pend;
    old_pend = m_pend;
    if (m_mode == 0) begin
      m_slot = 0;
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      m_slot = (m_slot + 1) % 64;
      if (!run) m_mode = 2;
    end else begin
      if (run) begin
        m_slot = (m_slot + 1) % 64; m_mode = 1;
      end else if (m_slot == 63) begin
        m_slot = 0; m_mode = 0;
      end else begin
        m_slot = m_slot + 1;
      end
    end
    if (m_mode == 0) m_zv = -1;
    else if (m_slot % 8 == 0) begin
      if (old_pend[m_slot / 8]) begin
        m_zv = m_slot / 8;
        m_pend[m_slot / 8] = 1'b0;
      end else begin
        m_zv = -1;
      end
    end
    if (non) m_pend[vx] = 1'b1;
    m_frame = (m_mode == 1) && (m_slot == 0);
  endtask

  task automatic check_all();
    logic [7:0] exp_zero;
    exp_zero = (m_mode != 0 && m_zv == m_slot / 8) ? 8'hFF : 8'h00;
    chk("xxxx",           64'(bus.xxxx),           64'(m_slot));
    chk("frame_start",    64'(bus.frame_start),    64'(m_frame));
    chk("osc_accum_zero", 64'(bus.osc_accum_zero), 64'(exp_zero));
    chk("reset_pending",  64'(bus.reset_pending),  64'(m_pend));
    chk("running",        64'(bus.running),        64'(m_mode != 0));
  endtask

  // One clock: drive, edge, model, check 1 time unit after the edge.
  task automatic cyc(input bit run, input bit non, input int vx);
    bus.run     = run;
    bus.note_on = non;
    bus.note_vx = 3'(vx);
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_edge(run, non, vx);
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_slot != target && guard < 200) begin
      cyc(1'b1, 1'b0, 0);
      guard++;
    end
    chk("run_to_bound", 64'(guard < 200), 64'd1);
  endtask

  function automatic bit zero_on_voice(input int v);
    return (bus.osc_accum_zero == 8'hFF) && (int'(bus.xxxx[5:3]) == v);
  endfunction

  initial begin
    int cnt, cnt0, cnt7, n;
    bit r;
    bus.run = 1'b0; bus.note_on = 1'b0; bus.note_vx = '0;

    // Reset values held during reset
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4);
    rstn = 1'b1;

    // Frame sequencing: 130 cycles of run
    cnt = 0;
    for (int i = 0; i < 130; i++) begin
      cyc(1'b1, 1'b0, 0);
      if (bus.frame_start) cnt++;
      if (i == 0)   chk("first_frame_start", 64'(bus.frame_start), 64'd1);
      if (i == 63)  chk("slot_63", 64'(bus.xxxx), 64'd63);
      if (i == 64)  chk("wrap_frame_start", 64'(bus.frame_start), 64'd1);
    end
    chk("frame_start_count", 64'(cnt), 64'd3);

    // Single request served in the same frame
    run_to(3);
    cyc(1'b1, 1'b1, 5);
    chk("pend5_set", 64'(bus.reset_pending[5]), 64'd1);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b0, 0);
      if (bus.xxxx == 6'd40) chk("pend5_clr", 64'(bus.reset_pending[5]), 64'd0);
      if (zero_on_voice(5)) cnt++;
    end
    chk("v5_zero_cycles", 64'(cnt), 64'd8);

    // Late request: misses current visit, served next frame
    run_to(16);
    cyc(1'b1, 1'b1, 2);
    cnt = 0; n = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b1, 1'b0, 0);
      if (zero_on_voice(2)) begin
        cnt++;
        if (i < 30) n++;
      end
    end
    chk("v2_late_same_frame", 64'(n), 64'd0);
    chk("v2_late_next_frame", 64'(cnt), 64'd8);

    // Two requests, then set-wins on voice 7's service edge
    run_to(50);
    cyc(1'b1, 1'b1, 0);
    cyc(1'b1, 1'b1, 7);
    run_to(55);
    cyc(1'b1, 1'b1, 7);
    chk("v7_pend_kept", 64'(bus.reset_pending[7]), 64'd1);
    cnt0 = 0; cnt7 = 0;
    if (zero_on_voice(7)) cnt7++;
    for (int i = 0; i < 71; i++) begin
      cyc(1'b1, 1'b0, 0);
      if (zero_on_voice(0)) cnt0++;
      if (zero_on_voice(7)) cnt7++;
    end
    chk("v0_zero_cycles", 64'(cnt0), 64'd8);
    chk("v7_zero_twice", 64'(cnt7), 64'd16);

    // Stop handling and request while idle
    run_to(20);
    n = 0;
    while (m_mode != 0 && n < 100) begin
      cyc(1'b0, 1'b0, 0);
      n++;
    end
    chk("stop_len", 64'(n), 64'd44);
    cyc(1'b0, 1'b1, 3);
    chk("idle_pend3", 64'(bus.reset_pending[3]), 64'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 0);
    chk("idle_no_zero", 64'(bus.osc_accum_zero), 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 0);
      if (zero_on_voice(3)) cnt++;
    end
    chk("v3_after_run", 64'(cnt), 64'd8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 9) != 0);
      if (m_mode == 1 && m_slot == 63) r = 1'b1;
      cyc(r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 0);

    // Asynchronous reset mid-zeroing of voice 5
    run_to(30);
    cyc(1'b1, 1'b1, 5);
    run_to(42);
    chk("v5_zeroing_pre_rst", 64'(bus.osc_accum_zero), 64'hFF);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_xxxx", 64'(bus.xxxx), 64'd0);
    chk("arst_zero", 64'(bus.osc_accum_zero), 64'd0);
    chk("arst_pend", 64'(bus.reset_pending), 64'd0);
    chk("arst_running", 64'(bus.running), 64'd0);
    chk("arst_frame", 64'(bus.frame_start), 64'd0);
    cyc(1'b1, 1'b0, 0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/osc_slot_scheduler.md
# osc_slot_scheduler

Time-slot sequencer and accumulator-reset scheduler for the oscillator datapath. It generates the time-multiplexed slot index `xxxx` (voice, oscillator, envelope sub-slot) that steps the shared NCO/sine pipeline through every voice. It also queues per-voice note-on phase-reset requests and drives `osc_accum_zero` exactly during the slots of the requesting voice. It sits between the voice allocator and the osc/nco instances and runs on the oscillator clock.

## Interface
Parameters:
- VOICES, 8, number of voices; equals 2**V_WIDTH.
- V_OSC, 4, oscillators per voice; equals 2**O_WIDTH.
- V_ENVS, 8, slots per voice; equals 2**E_WIDTH.
- V_WIDTH, 3, voice index width.
- O_WIDTH, 2, oscillator index width.
- OE_WIDTH, 1, sub-slot width per oscillator.
- E_WIDTH, O_WIDTH+OE_WIDTH, slot-within-voice width.

Ports:
- sCLK_XVXOSC  in  1  oscillator slot clock; all logic on rising edge.
- reset_data_N  in  1  reset, asynchronous, active-low.
- run  in  1  level; enables slot sequencing.
- note_on  in  1  single-cycle request to phase-reset voice note_vx.
- note_vx  in  V_WIDTH  voice index qualified by note_on.
- xxxx  out  V_WIDTH+E_WIDTH  current slot {vx, ox, oe}; registered.
- frame_start  out  1  high while xxxx==0 in RUN state.
- osc_accum_zero  out  V_ENVS  all-ones while the current voice is being reset, otherwise 0.
- reset_pending  out  VOICES  per-voice queued-request bits.
- running  out  1  high in RUN or STOP.

## Operation
- Slot counter `slot` (V_WIDTH+E_WIDTH bits) drives xxxx directly: vx=slot[MSBs], e=slot[E_WIDTH-1:0].
- FSM:
  - IDLE: slot held at 0; frame_start=0; osc_accum_zero=0. Goes to RUN when run=1.
  - RUN: slot increments by 1 each cycle and wraps from VOICES*V_ENVS-1 to 0. Goes to STOP when run=0.
  - STOP: keeps incrementing until slot reaches max, then goes to IDLE with slot=0 on the wrap. If run=1 is seen in STOP, returns to RUN with no discontinuity in slot.
- Request queue:
  - note_on=1 sets reset_pending[note_vx] on the next edge, in any state, including IDLE.
  - Service happens on the edge where the next slot has e==0 and reset_pending[next vx]==1:
    - a zeroing flag is set for that voice;
    - its pending bit is cleared;
    - osc_accum_zero is all-ones for the V_ENVS cycles where xxxx belongs to that voice.
  - The zeroing flag is cleared at the voice boundary.
  - Set and service of the same bit on the same edge: set wins. The bit stays 1, so the voice is served again on its next visit. This means one extra reset, which is harmless.
  - Repeated note_on for an already-pending voice has no additional effect.
- No service in IDLE. Pending bits persist until RUN/STOP reaches the voice.

## Timing
- Reset values (asynchronous): xxxx=0, frame_start=0, osc_accum_zero=0, reset_pending=0, running=0, FSM=IDLE.
- Reset asserted mid-frame or mid-zeroing: all outputs go to reset values immediately; queued requests are lost.
- IDLE→RUN: run sampled high at edge N. At edge N, xxxx stays 0 and frame_start=1 with running=1. At edge N+1, xxxx=1.
- Frame period is VOICES*V_ENVS cycles (64 at defaults). frame_start is high for exactly 1 cycle per frame.
- osc_accum_zero is registered and cycle-aligned with xxxx, so it applies to the slot shown on xxxx in the same cycle.
- Request latency: from the note_on edge to the first zeroed slot is at least 1 cycle and at most VOICES*V_ENVS cycles.
  - A request arriving in the cycle where xxxx already has e==0 for that voice misses that visit. It is served on the next frame.

## Test plan
- Reset values and frame sequencing:
  - Stimulus: reset, then run=1 for 130 cycles.
  - Required: all reset values hold during reset; xxxx counts 0..63 and wraps; frame_start high at cycles 0, 64 and 128 only.
- Single request served in the same frame:
  - Stimulus: note_on with vx=5 while xxxx=3.
  - Required: reset_pending[5]=1; osc_accum_zero=8'hFF exactly while xxxx=40..47; pending bit clears when xxxx=40; osc_accum_zero=0 elsewhere.
- Request arriving too late:
  - Stimulus: note_on with vx=2 while xxxx=16.
  - Required: no zeroing at 16..23 of that frame; zeroing at 16..23 of the next frame.
- Two requests and set-wins:
  - Stimulus: note_on for vx=0 and vx=7; then a new note_on for vx=7 on the service edge of vx=7.
  - Required: voices 0 and 7 are each zeroed once; voice 7 is zeroed again in the following frame.
- Stop handling:
  - Stimulus: run=0 while xxxx=20.
  - Required: counting continues to 63; running stays 1 through 63; then xxxx=0, running=0 and frame_start=0. A note_on in IDLE sets pending, and the voice is served only after run=1.
- Asynchronous reset mid-zeroing:
  - Stimulus: assert reset_data_N=0 while xxxx=42, with voice 5 zeroing.
  - Required: osc_accum_zero, xxxx and reset_pending go to 0 with no clock edge.
